axi4_wr_packet_arbiter: RTL and testbench

Round-robin arbiter sharing one AXI4 write channel (AW/W/B) among NUM requesters at burst granularity. A requester owns the AW and W channels from grant until its WLAST beat is accepted. B responses are routed back through an order FIFO of granted indices. It sits in front of the write packet FIFO or the memory-controller write port, in one clock domain.

---
 rtl/axi4_wr_packet_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_axi4_wr_packet_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_wr_packet_arbiter.sv
// axi4_wr_packet_arbiter: round-robin arbiter sharing one AXI4 write channel
// (AW/W/B) among NUM requesters at burst granularity. The granted requester
// owns AW and W until its WLAST beat is accepted. B responses are steered back
// via an order FIFO of granted indices. The slave must return B in AW order.
// Optional W-phase stall watchdog: define AXI4_WR_ARB_WDOG_EN.
module axi4_wr_packet_arbiter #(
  parameter int NUM      = 4,
  parameter int ASIZE    = 32,
  parameter int LSIZE    = 8,
  parameter int IDSIZE   = 4,
  parameter int DSIZE    = 32,
  parameter int OUTSTD   = 4,
  parameter int WDOG_CYC = 1024
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  input  logic [NUM-1:0]        s_awvalid,
  output logic [NUM-1:0]        s_awready,
  input  logic [NUM*ASIZE-1:0]  s_awaddr,
  input  logic [NUM*LSIZE-1:0]  s_awlen,
  input  logic [NUM*IDSIZE-1:0] s_awid,
  input  logic [NUM-1:0]        s_wvalid,
  output logic [NUM-1:0]        s_wready,
  input  logic [NUM-1:0]        s_wlast,
  input  logic [NUM*DSIZE-1:0]  s_wdata,
  output logic [NUM-1:0]        s_bvalid,
  input  logic [NUM-1:0]        s_bready,
  output logic [1:0]            s_bresp,
  output logic [IDSIZE-1:0]     s_bid,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ASIZE-1:0]      m_awaddr,
  output logic [LSIZE-1:0]      m_awlen,
  output logic [IDSIZE-1:0]     m_awid,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DSIZE-1:0]      m_wdata,
  output logic                  m_wlast,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  input  logic [IDSIZE-1:0]     m_bid,
  output logic                  wdog_err
);

  localparam int GW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int PW = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
  localparam int CW = $clog2(OUTSTD + 1);

  typedef enum logic [1:0] {IDLE, AW, WDATA} state_t;

  state_t        state;
  logic [GW-1:0] g;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] pick;
  logic [GW-1:0] head;
  logic [GW-1:0] ord_mem [OUTSTD];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] ord_cnt;
  logic          ord_full;
  logic          ord_empty;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTD - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ord_full  = (ord_cnt == CW'(OUTSTD));
  assign ord_empty = (ord_cnt == '0);
  assign head      = ord_mem[rd_ptr];
  assign aw_hs     = m_awvalid & m_awready;
  assign w_hs      = m_wvalid & m_wready;
  assign b_hs      = m_bvalid & m_bready;
  assign s_bresp   = m_bresp;
  assign s_bid     = m_bid;

  // Round-robin pick: nearest valid requester after last_grant, with wrap.
  always_comb begin
    int d;
    int best;
    d    = 0;
    best = NUM;
    pick = last_grant;
    for (int i = 0; i < NUM; i++) begin
      d = i - int'(last_grant) - 1;
      if (d < 0) d = d + NUM;
      if (s_awvalid[i] && d < best) begin
        best = d;
        pick = GW'(i);
      end
    end
  end

  // Channel steering: AW/W from the granted requester, B to the FIFO head.
  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awid    = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (g == GW'(i)) begin
        m_awaddr     = s_awaddr[i*ASIZE +: ASIZE];
        m_awlen      = s_awlen[i*LSIZE +: LSIZE];
        m_awid       = s_awid[i*IDSIZE +: IDSIZE];
        m_wdata      = s_wdata[i*DSIZE +: DSIZE];
        m_awvalid    = (state == AW) && s_awvalid[i];
        s_awready[i] = (state == AW) && m_awready;
        m_wvalid     = (state == WDATA) && s_wvalid[i];
        m_wlast      = (state == WDATA) && s_wlast[i];
        s_wready[i]  = (state == WDATA) && m_wready;
      end
      if (!ord_empty && head == GW'(i)) begin
        s_bvalid[i] = m_bvalid;
        m_bready    = s_bready[i];
      end
    end
  end

  // Burst-level FSM: arbitrate in IDLE, own AW until accepted, own W until WLAST.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state      <= IDLE;
      g          <= '0;
      last_grant <= GW'(NUM - 1);
    end else begin
      case (state)
        IDLE:    if ((|s_awvalid) && !ord_full) begin
                   g     <= pick;
                   state <= AW;
                 end
        AW:      if (aw_hs) state <= WDATA;
        WDATA:   if (w_hs && m_wlast) begin
                   last_grant <= g;
                   state      <= IDLE;
                 end
        default: state <= IDLE;
      endcase
    end
  end

  // Order FIFO control: push on AW accept, pop on B accept, both may coincide.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ord_cnt <= '0;
    end else begin
      if (aw_hs) wr_ptr <= ptr_inc(wr_ptr);
      if (b_hs)  rd_ptr <= ptr_inc(rd_ptr);
      if (aw_hs && !b_hs)      ord_cnt <= ord_cnt + CW'(1);
      else if (!aw_hs && b_hs) ord_cnt <= ord_cnt - CW'(1);
    end
  end

  // Order FIFO storage of granted indices.
  always_ff @(posedge axi_aclk) begin
    if (aw_hs) ord_mem[wr_ptr] <= g;
  end

`ifdef AXI4_WR_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0] wdog_cnt;

  // Watchdog: count W-phase cycles without a beat; flag is sticky until reset.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else if (state == AW && aw_hs) begin
      wdog_cnt <= '0;
    end else if (state == WDATA) begin
      if (w_hs)                         wdog_cnt <= '0;
      else if (wdog_cnt != WW'(WDOG_CYC)) wdog_cnt <= wdog_cnt + WW'(1);
      if (!w_hs && wdog_cnt == WW'(WDOG_CYC - 1)) wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_wr_packet_arbiter.sv
// Bench for axi4_wr_packet_arbiter: requester and slave models, scoreboard
// queues filled at stimulus time and drained by a negedge monitor.
module tb_axi4_wr_packet_arbiter;
  localparam int NUM = 4, ASIZE = 32, LSIZE = 8, IDSIZE = 4, DSIZE = 32, OUTSTD = 4;
`ifdef AXI4_WR_ARB_WDOG_EN
  localparam logic WDOG_EXP = 1'b1;
`else
  localparam logic WDOG_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM-1:0]        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [NUM*ASIZE-1:0]  s_awaddr;
  logic [NUM*LSIZE-1:0]  s_awlen;
  logic [NUM*IDSIZE-1:0] s_awid;
  logic [NUM*DSIZE-1:0]  s_wdata;
  logic [1:0]            s_bresp, m_bresp;
  logic [IDSIZE-1:0]     s_bid, m_bid, m_awid;
  logic                  m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [ASIZE-1:0]      m_awaddr;
  logic [LSIZE-1:0]      m_awlen;
  logic [DSIZE-1:0]      m_wdata;
  logic                  wdog_err;

  axi4_wr_packet_arbiter #(
    .NUM(NUM), .ASIZE(ASIZE), .LSIZE(LSIZE), .IDSIZE(IDSIZE), .DSIZE(DSIZE),
    .OUTSTD(OUTSTD), .WDOG_CYC(16)
  ) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .wdog_err(wdog_err)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; } aw_t;
  typedef struct { logic [31:0] d; logic l; } w_t;
  typedef struct { logic [3:0] oh; logic [3:0] id; logic [1:0] resp; } b_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  b_t  b_q[$];
  logic [3:0] slv_q[$];
  int  aw_cyc_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int aw_cnt = 0;
  int w_beats = 0;
  int b_cyc = 0;
  int b_budget = 0;
  logic aw_rdy = 1'b1;
  logic w_rdy = 1'b1;

  logic [NUM-1:0] pend_aw = '0, pend_w = '0, stall = '0, hs_aw = '0, hs_w = '0;
  logic [31:0] raddr [NUM];
  logic [7:0]  rlen  [NUM];
  logic [3:0]  rid   [NUM];
  int          beat  [NUM];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wdat(input int i, input logic [3:0] id, input int b);
    return {8'(i), 4'h0, id, 8'(b), 8'h5A};
  endfunction

  function automatic logic [1:0] resp_of(input logic [3:0] id);
    return id[3:2];
  endfunction

  task automatic drive_all();
    for (int i = 0; i < NUM; i++) begin
      s_awvalid[i] = pend_aw[i];
      s_awaddr[i*ASIZE +: ASIZE] = raddr[i];
      s_awlen[i*LSIZE +: LSIZE] = rlen[i];
      s_awid[i*IDSIZE +: IDSIZE] = rid[i];
      s_wvalid[i] = pend_w[i] && !stall[i];
      s_wdata[i*DSIZE +: DSIZE] = wdat(i, rid[i], beat[i]);
      s_wlast[i] = (beat[i] == int'(rlen[i]));
      s_bready[i] = 1'b1;
    end
    m_awready = aw_rdy;
    m_wready  = w_rdy;
    m_bvalid  = (b_budget > 0) && (slv_q.size() > 0);
    m_bid     = (slv_q.size() > 0) ? slv_q[0] : 4'h0;
    m_bresp   = resp_of(m_bid);
  endtask

  task automatic req(input int i, input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    raddr[i] = a;
    rlen[i] = l;
    rid[i] = id;
    pend_aw[i] = 1'b1;
    aw_q.push_back('{a, l, id});
    for (int b = 0; b <= int'(l); b++) w_q.push_back('{wdat(i, id, b), (b == int'(l))});
    b_q.push_back('{4'(1 << i), id, resp_of(id)});
    drive_all();
  endtask

  task automatic flush();
    aw_q.delete();
    w_q.delete();
    b_q.delete();
    slv_q.delete();
    pend_aw = '0;
    pend_w = '0;
    stall = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    flush();
    drive_all();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((aw_q.size() + w_q.size() + b_q.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(n < 300), 1);
    @(posedge clk); #2;
  endtask

  task automatic wait_aw(input int n, input string tag);
    int k;
    k = 0;
    while (aw_cnt < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    chk({tag, "_seen"}, 64'(aw_cnt >= n), 1);
  endtask

  // Monitor on negedge, requester/slave model update just after posedge.
  initial begin
    aw_t ea;
    w_t  ew;
    b_t  eb;
    logic m_aw_hs, m_b_hs;
    logic [3:0] awid_s;
    for (int i = 0; i < NUM; i++) begin
      raddr[i] = '0; rlen[i] = '0; rid[i] = '0; beat[i] = 0;
    end
    drive_all();
    forever begin
      @(negedge clk);
      m_aw_hs = m_awvalid && m_awready;
      m_b_hs  = m_bvalid && m_bready;
      awid_s  = m_awid;
      if (m_aw_hs) begin
        aw_cnt++;
        aw_cyc_q.push_back(cyc);
        if (aw_q.size() == 0) chk("aw_unexpected", m_awvalid, 0);
        else begin
          ea = aw_q.pop_front();
          chk("aw_addr", m_awaddr, ea.addr);
          chk("aw_len", m_awlen, ea.len);
          chk("aw_id", m_awid, ea.id);
        end
      end
      if (m_wvalid && m_wready) begin
        w_beats++;
        if (w_q.size() == 0) chk("w_unexpected", m_wvalid, 0);
        else begin
          ew = w_q.pop_front();
          chk("w_data", m_wdata, ew.d);
          chk("w_last", m_wlast, ew.l);
        end
      end
      if (m_b_hs) begin
        b_cyc = cyc;
        if (b_q.size() == 0) chk("b_unexpected", m_bvalid, 0);
        else begin
          eb = b_q.pop_front();
          chk("b_route", s_bvalid, eb.oh);
          chk("b_id", s_bid, eb.id);
          chk("b_resp", s_bresp, eb.resp);
        end
      end
      for (int i = 0; i < NUM; i++) begin
        hs_aw[i] = s_awvalid[i] && s_awready[i];
        hs_w[i]  = s_wvalid[i] && s_wready[i];
      end
      @(posedge clk); #1;
      if (rst) begin
        pend_aw = '0;
        pend_w = '0;
        slv_q.delete();
      end else begin
        for (int i = 0; i < NUM; i++) begin
          if (hs_aw[i]) begin
            pend_aw[i] = 1'b0;
            pend_w[i] = 1'b1;
            beat[i] = 0;
          end
          if (hs_w[i]) begin
            if (beat[i] == int'(rlen[i])) pend_w[i] = 1'b0;
            beat[i]++;
          end
        end
        if (m_aw_hs) slv_q.push_back(awid_s);
        if (m_b_hs && slv_q.size() > 0) begin
          void'(slv_q.pop_front());
          if (b_budget > 0) b_budget--;
        end
      end
      drive_all();
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base, req_cyc, wb, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid, wdog_err}, 0);
    chk("rst_state", 64'(int'(dut.state)), 0);
    chk("rst_fifo", 64'(dut.ord_cnt), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Single requester 1, 4 beats, OKAY response
    b_budget = 1000;
    @(posedge clk); #2;
    aw_cyc_q.delete();
    req_cyc = cyc;
    req(1, 32'h0000_1100, 8'd3, 4'h1);
    wait_done("t1");
    chk("t1_aw_latency", 64'(aw_cyc_q[0] - req_cyc), 1);
    chk("t1_fifo_empty", 64'(dut.ord_cnt), 0);
    chk("t1_state", 64'(int'(dut.state)), 0);

    // All four requesters from reset: grant order 0,1,2,3,0 with 3-cycle spacing
    pulse_reset();
    aw_cyc_q.delete();
    base = aw_cnt;
    req(0, 32'h0000_2000, 8'd0, 4'h2);
    req(1, 32'h0000_2100, 8'd0, 4'h3);
    req(2, 32'h0000_2200, 8'd0, 4'h4);
    req(3, 32'h0000_2300, 8'd0, 4'h5);
    wait_aw(base + 1, "t2_first");
    repeat (2) @(posedge clk); #2;
    req(0, 32'h0000_2400, 8'd0, 4'h6);
    wait_done("t2");
    chk("t2_aw_count", 64'(aw_cyc_q.size()), 5);
    for (int i = 0; i < 4; i++) chk("t2_rr_gap", 64'(aw_cyc_q[i+1] - aw_cyc_q[i]), 3);

    // Outstanding limit: 4 AW accepted with B held, fifth waits for one B
    b_budget = 0;
    drive_all();
    aw_cyc_q.delete();
    base = aw_cnt;
    req(1, 32'h0000_3100, 8'd0, 4'h7);
    req(2, 32'h0000_3200, 8'd0, 4'h8);
    req(3, 32'h0000_3300, 8'd0, 4'h9);
    req(0, 32'h0000_3000, 8'd0, 4'hA);
    wait_aw(base + 4, "t3_four");
    repeat (3) @(posedge clk); #2;
    req(1, 32'h0000_3500, 8'd0, 4'hB);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t3_aw_count", 64'(aw_cnt - base), 4);
    chk("t3_idle_hold", 64'(int'(dut.state)), 0);
    chk("t3_fifo_full", 64'(dut.ord_cnt), 4);
    @(posedge clk); #2;
    b_budget = 1;
    drive_all();
    wait_aw(base + 5, "t3_fifth");
    chk("t3_release_gap", 64'(aw_cyc_q[4] - b_cyc), 2);
    @(posedge clk); #2;
    b_budget = 1000;
    drive_all();
    wait_done("t3");

    // B routing for grants 2,0,3
    b_budget = 0;
    drive_all();
    base = aw_cnt;
    req(2, 32'h0000_4200, 8'd1, 4'h9);
    wait_aw(base + 1, "t4_a");
    repeat (4) @(posedge clk); #2;
    req(0, 32'h0000_4000, 8'd0, 4'h4);
    wait_aw(base + 2, "t4_b");
    repeat (4) @(posedge clk); #2;
    req(3, 32'h0000_4300, 8'd2, 4'hF);
    wait_aw(base + 3, "t4_c");
    repeat (6) @(posedge clk); #2;
    b_budget = 1000;
    drive_all();
    wait_done("t4");

    // Reset after 2 of 8 beats, then a clean burst from requester 0
    b_budget = 0;
    drive_all();
    wb = w_beats;
    req(0, 32'h0000_5000, 8'd7, 4'h3);
    k = 0;
    while (w_beats < wb + 2 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #2;
    chk("t5_two_beats", 64'(w_beats - wb), 2);
    rst = 1'b1;
    flush();
    drive_all();
    @(negedge clk);
    chk("t5_rst_outs", {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}, 0);
    chk("t5_rst_state", 64'(int'(dut.state)), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    b_budget = 1000;
    req(0, 32'h0000_5100, 8'd1, 4'h6);
    wait_done("t5");

    // W-phase stall of 20 cycles against a 16-cycle watchdog
    base = aw_cnt;
    stall[2] = 1'b1;
    req(2, 32'h0000_6200, 8'd1, 4'h2);
    wait_aw(base + 1, "t6");
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t6_wdog_stall", wdog_err, WDOG_EXP);
    @(posedge clk); #2;
    stall[2] = 1'b0;
    drive_all();
    wait_done("t6");
    chk("t6_wdog_after", wdog_err, WDOG_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
